// File: rtl/mio_bus_hs_pkg.sv
// mio_pkg: shared definitions for the handshaked memory-mapped I/O bus.
//   - Region codes taken from addr_bus[31:28].
//   - FSM state type of the bus controller.
//   - Bit positions of the keyboard status/data word.
package mio_pkg;

  localparam logic [3:0] REG_RAM   = 4'h0;
  localparam logic [3:0] REG_VRAM  = 4'hC;
  localparam logic [3:0] REG_KB    = 4'hD;
  localparam logic [3:0] REG_GPIOE = 4'hE;
  localparam logic [3:0] REG_GPIOF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_VWAIT = 2'd2
  } mio_state_e;

  // Keyboard word: {not_empty, overflow, 6'b0, count[7:0], head}
  localparam int KB_BIT_NE   = 31;
  localparam int KB_BIT_OVF  = 30;
  localparam int KB_CNT_LSB  = 16;
  localparam int KB_CNT_W    = 8;

endpackage

// File: rtl/mio_bus_hs_if.sv
// mio_bus_hs_if: CPU-side request/response handshake of the I/O bus.
//   master : the CPU (drives mem_r, mem_w, addr_bus, Cpu_data2bus)
//   slave  : the bus controller (drives bus_ready, Cpu_data4bus)
interface mio_bus_hs_if #(
  parameter int DATA_W = 32
) ();

  logic              mem_r;
  logic              mem_w;
  logic [DATA_W-1:0] addr_bus;
  logic [DATA_W-1:0] Cpu_data2bus;
  logic              bus_ready;
  logic [DATA_W-1:0] Cpu_data4bus;

  modport master (
    output mem_r, mem_w, addr_bus, Cpu_data2bus,
    input  bus_ready, Cpu_data4bus
  );

  modport slave (
    input  mem_r, mem_w, addr_bus, Cpu_data2bus,
    output bus_ready, Cpu_data4bus
  );

endinterface

// File: rtl/mio_bus_hs_kb_fifo.sv
// mio_kb_fifo: keyboard scan-code FIFO with sticky overflow flag.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   push, din      write a key code (dropped when full unless popping too)
//   pop            remove the head entry (ignored when empty)
//   clr_ovf        clear the overflow flag (a concurrent overflow re-sets it)
//   dout           head entry, 0 when empty
//   count          number of stored entries, 0..KB_DEPTH
//   empty, full    occupancy flags
//   overflow       sticky: a push was dropped because the FIFO was full
module mio_kb_fifo #(
  parameter int KB_W     = 10,
  parameter int KB_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [KB_W-1:0]                 din,
  input  logic                            clr_ovf,
  output logic [KB_W-1:0]                 dout,
  output logic [$clog2(KB_DEPTH+1)-1:0]   count,
  output logic                            empty,
  output logic                            full,
  output logic                            overflow
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = $clog2(KB_DEPTH + 1);

  logic [KB_W-1:0] mem_q [KB_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(KB_DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = (ovf_q & ~clr_ovf) | (push & ~do_push);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mio_bus_hs.sv
// mio_bus_hs: handshaked memory-mapped I/O bus between CPU and RAM, GPIO,
// counter, PS/2 keyboard FIFO and VRAM.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cpu (slave modport)      mem_r/mem_w/addr_bus/Cpu_data2bus in,
//                            bus_ready pulse and registered Cpu_data4bus out
//   ram_*                    data RAM: async read data in, address, write data, we pulse
//   BTN, SW, led_out         GPIO read sources
//   counter_out, counter*_out counter read sources
//   GPIO*_we, counter_we     peripheral write pulses, Peripheral_in write data
//   ps2kb_key/valid          keyboard code strobe into the internal FIFO
//   vram_*                   VRAM write port, vram_we held until vram_ack
module mio_bus_hs
  import mio_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RAM_AW   = 10,
  parameter int VRAM_AW  = 18,
  parameter int VRAM_DW  = 12,
  parameter int KB_W     = 10,
  parameter int KB_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  mio_bus_hs_if.slave        cpu,
  input  logic [DATA_W-1:0]  ram_data_out,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_data_in,
  output logic               data_ram_we,
  input  logic [3:0]         BTN,
  input  logic [15:0]        SW,
  input  logic [15:0]        led_out,
  input  logic [DATA_W-1:0]  counter_out,
  input  logic               counter0_out,
  input  logic               counter1_out,
  input  logic               counter2_out,
  output logic               GPIOf0000000_we,
  output logic               GPIOe0000000_we,
  output logic               counter_we,
  output logic [DATA_W-1:0]  Peripheral_in,
  input  logic [KB_W-1:0]    ps2kb_key,
  input  logic               ps2kb_valid,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_data,
  input  logic               vram_ack
);

  localparam int KCW = $clog2(KB_DEPTH + 1);

  mio_state_e         state_q, state_d;
  logic               bus_ready_q, bus_ready_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               ram_we_q, ram_we_d;
  logic               gf_we_q, gf_we_d;
  logic               ge_we_q, ge_we_d;
  logic               cnt_we_q, cnt_we_d;
  logic [DATA_W-1:0]  ram_din_q, ram_din_d;
  logic [DATA_W-1:0]  periph_q, periph_d;
  logic               vram_we_q, vram_we_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [VRAM_DW-1:0] vram_data_q, vram_data_d;

  logic [3:0]         region;
  logic               sel_hi;
  logic               req, is_wr;
  logic [DATA_W-1:0]  rd_mux, kb_word;

  logic               kb_pop, kb_clr;
  logic [KB_W-1:0]    kb_dout;
  logic [KCW-1:0]     kb_count;
  logic               kb_empty, kb_full, kb_ovf;

  // Address bits outside every decoded field, gathered so they read as intentionally unused.
  logic               unused_addr;
  assign unused_addr = ^{cpu.addr_bus[1:0], cpu.addr_bus[DATA_W-5:VRAM_AW+2], kb_full};

  assign region   = cpu.addr_bus[DATA_W-1 -: 4];
  assign sel_hi   = cpu.addr_bus[2];
  assign req      = cpu.mem_r | cpu.mem_w;
  assign is_wr    = cpu.mem_w;      // write wins when both are asserted
  assign ram_addr = cpu.addr_bus[RAM_AW+1:2];

  mio_kb_fifo #(
    .KB_W    (KB_W),
    .KB_DEPTH(KB_DEPTH)
  ) u_kb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ps2kb_valid),
    .pop     (kb_pop),
    .din     (ps2kb_key),
    .clr_ovf (kb_clr),
    .dout    (kb_dout),
    .count   (kb_count),
    .empty   (kb_empty),
    .full    (kb_full),
    .overflow(kb_ovf)
  );

  always_comb begin
    kb_word                          = '0;
    kb_word[KB_BIT_NE]               = ~kb_empty;
    kb_word[KB_BIT_OVF]              = kb_ovf;
    kb_word[KB_CNT_LSB +: KB_CNT_W]  = KB_CNT_W'(kb_count);
    kb_word[KB_W-1:0]                = kb_dout;
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM:   rd_mux = ram_data_out;
      REG_KB:    rd_mux = kb_word;
      REG_GPIOE: rd_mux = {counter0_out, counter1_out, counter2_out, 13'b0, led_out};
      REG_GPIOF: rd_mux = sel_hi ? counter_out : {BTN, 12'b0, SW};
      default:   rd_mux = '0;       // VRAM reads and unmapped regions
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_ready_d = 1'b0;
    ram_we_d    = 1'b0;
    gf_we_d     = 1'b0;
    ge_we_d     = 1'b0;
    cnt_we_d    = 1'b0;
    rdata_d     = rdata_q;
    ram_din_d   = ram_din_q;
    periph_d    = periph_q;
    vram_we_d   = vram_we_q;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    kb_pop      = 1'b0;
    kb_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_wr && region == REG_VRAM) begin
            state_d     = ST_VWAIT;
            vram_we_d   = 1'b1;
            vram_addr_d = cpu.addr_bus[VRAM_AW+1:2];
            vram_data_d = cpu.Cpu_data2bus[VRAM_DW-1:0];
          end else begin
            state_d     = ST_RESP;
            bus_ready_d = 1'b1;
            ram_din_d   = cpu.Cpu_data2bus;
            periph_d    = cpu.Cpu_data2bus;
            if (is_wr) begin
              rdata_d = '0;
              case (region)
                REG_RAM:   ram_we_d = 1'b1;
                REG_GPIOE: ge_we_d  = 1'b1;
                REG_GPIOF: begin
                  gf_we_d  = ~sel_hi;
                  cnt_we_d = sel_hi;
                end
                default: ;             // keyboard and unmapped writes are ignored
              endcase
            end else begin
              // Data is captured from the head before the pop takes effect.
              rdata_d = rd_mux;
              if (region == REG_KB) begin
                kb_pop = ~sel_hi;
                kb_clr = sel_hi;
              end
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_VWAIT: begin
        if (vram_ack) begin
          state_d     = ST_RESP;
          vram_we_d   = 1'b0;
          bus_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_ready_q <= 1'b0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      gf_we_q     <= 1'b0;
      ge_we_q     <= 1'b0;
      cnt_we_q    <= 1'b0;
      ram_din_q   <= '0;
      periph_q    <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_ready_q <= bus_ready_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      gf_we_q     <= gf_we_d;
      ge_we_q     <= ge_we_d;
      cnt_we_q    <= cnt_we_d;
      ram_din_q   <= ram_din_d;
      periph_q    <= periph_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign cpu.bus_ready    = bus_ready_q;
  assign cpu.Cpu_data4bus = rdata_q;
  assign ram_data_in      = ram_din_q;
  assign data_ram_we      = ram_we_q;
  assign GPIOf0000000_we  = gf_we_q;
  assign GPIOe0000000_we  = ge_we_q;
  assign counter_we       = cnt_we_q;
  assign Peripheral_in    = periph_q;
  assign vram_we          = vram_we_q;
  assign vram_addr        = vram_addr_q;
  assign vram_data        = vram_data_q;

endmodule

// File: tb/tb_mio_bus_hs.sv
// Directed testbench for mio_bus_hs with hand-computed expected values.
module tb_mio_bus_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_data_out;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data_in;
  logic        data_ram_we;
  logic [3:0]  BTN;
  logic [15:0] SW;
  logic [15:0] led_out;
  logic [31:0] counter_out;
  logic        counter0_out, counter1_out, counter2_out;
  logic        GPIOf0000000_we, GPIOe0000000_we, counter_we;
  logic [31:0] Peripheral_in;
  logic [9:0]  ps2kb_key;
  logic        ps2kb_valid;
  logic        vram_we;
  logic [17:0] vram_addr;
  logic [11:0] vram_data;
  logic        vram_ack;

  mio_bus_hs_if #(.DATA_W(32)) cpu_if ();

  mio_bus_hs dut (
    .clk            (clk),
    .rst            (rst),
    .cpu            (cpu_if),
    .ram_data_out   (ram_data_out),
    .ram_addr       (ram_addr),
    .ram_data_in    (ram_data_in),
    .data_ram_we    (data_ram_we),
    .BTN            (BTN),
    .SW             (SW),
    .led_out        (led_out),
    .counter_out    (counter_out),
    .counter0_out   (counter0_out),
    .counter1_out   (counter1_out),
    .counter2_out   (counter2_out),
    .GPIOf0000000_we(GPIOf0000000_we),
    .GPIOe0000000_we(GPIOe0000000_we),
    .counter_we     (counter_we),
    .Peripheral_in  (Peripheral_in),
    .ps2kb_key      (ps2kb_key),
    .ps2kb_valid    (ps2kb_valid),
    .vram_we        (vram_we),
    .vram_addr      (vram_addr),
    .vram_data      (vram_data),
    .vram_ack       (vram_ack)
  );

  always #5 clk = ~clk;

  // Behavioural data RAM: async read, write on the clock edge.
  logic [31:0] ram_m [1024];
  assign ram_data_out = ram_m[ram_addr];
  always @(posedge clk) if (data_ram_we) ram_m[ram_addr] <= ram_data_in;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe activity seen during the most recent access.
  int          c_ram, c_gf, c_ge, c_cnt, c_rdy;
  logic [31:0] s_periph, s_ramdin;
  logic [9:0]  s_ramaddr;

  task automatic sample_strobes();
    if (data_ram_we)     begin c_ram++; s_ramaddr = ram_addr; s_ramdin = ram_data_in; end
    if (GPIOf0000000_we) begin c_gf++;  s_periph = Peripheral_in; end
    if (GPIOe0000000_we) begin c_ge++;  s_periph = Peripheral_in; end
    if (counter_we)      begin c_cnt++; s_periph = Peripheral_in; end
    if (cpu_if.bus_ready) c_rdy++;
  endtask

  // Called at a negedge; returns read data and request-to-ready latency in cycles.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic done;
    c_ram = 0; c_gf = 0; c_ge = 0; c_cnt = 0; c_rdy = 0;
    s_periph = '0; s_ramdin = '0; s_ramaddr = '0;
    rd = '0; lat = 0; done = 1'b0;
    cpu_if.mem_w = w; cpu_if.mem_r = r;
    cpu_if.addr_bus = a; cpu_if.Cpu_data2bus = d;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(posedge clk); @(negedge clk);
      sample_strobes();
      if (cpu_if.bus_ready) begin done = 1'b1; lat = i; rd = cpu_if.Cpu_data4bus; end
    end
    cpu_if.mem_w = 1'b0; cpu_if.mem_r = 1'b0;
    if (!done) chk("access_timeout", 32'(done), 32'd1);
    @(posedge clk); @(negedge clk);
    sample_strobes();
  endtask

  logic [31:0] rd;
  int          lat;
  int          vcnt;

  initial begin
    rst = 1'b0;
    cpu_if.mem_r = 1'b0; cpu_if.mem_w = 1'b0;
    cpu_if.addr_bus = '0; cpu_if.Cpu_data2bus = '0;
    BTN = 4'hA; SW = 16'h1234; led_out = 16'h00F0;
    counter_out = 32'hDEAD_BEEF;
    counter0_out = 1'b1; counter1_out = 1'b0; counter2_out = 1'b1;
    ps2kb_key = '0; ps2kb_valid = 1'b0; vram_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_ready", 32'(cpu_if.bus_ready), 32'd0);
    chk("rst_rdata", cpu_if.Cpu_data4bus, 32'd0);
    chk("rst_strobes", {28'd0, data_ram_we, GPIOf0000000_we, GPIOe0000000_we, counter_we}, 32'd0);
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // RAM write then read back
    access(1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678, rd, lat);
    chk("ram_w_we_cnt", 32'(c_ram), 32'd1);
    chk("ram_w_addr", 32'(s_ramaddr), 32'd4);
    chk("ram_w_din", s_ramdin, 32'h1234_5678);
    chk("ram_w_rdy_cnt", 32'(c_rdy), 32'd1);
    access(1'b0, 1'b1, 32'h0000_0010, 32'h0, rd, lat);
    chk("ram_r_lat", 32'(lat), 32'd1);
    chk("ram_r_data", rd, 32'h1234_5678);
    chk("ram_r_no_we", 32'(c_ram), 32'd0);

    // Counter write
    access(1'b1, 1'b0, 32'hF000_0004, 32'h0000_00AB, rd, lat);
    chk("cnt_we_cnt", 32'(c_cnt), 32'd1);
    chk("cnt_periph", s_periph, 32'h0000_00AB);
    chk("cnt_other_we", 32'(c_ram + c_gf + c_ge), 32'd0);

    // Peripheral reads
    access(1'b0, 1'b1, 32'hF000_0000, 32'h0, rd, lat);
    chk("gpiof_rd", rd, 32'hA000_1234);
    access(1'b0, 1'b1, 32'hF000_0004, 32'h0, rd, lat);
    chk("counter_rd", rd, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'hE000_0000, 32'h0, rd, lat);
    chk("gpioe_rd", rd, 32'hA000_00F0);
    access(1'b0, 1'b1, 32'h5000_0000, 32'h0, rd, lat);
    chk("unmapped_rd", rd, 32'h0);
    chk("unmapped_lat", 32'(lat), 32'd1);
    access(1'b1, 1'b0, 32'h5000_0000, 32'h77, rd, lat);
    chk("unmapped_w_we", 32'(c_ram + c_gf + c_ge + c_cnt), 32'd0);
    chk("unmapped_w_rdy", 32'(c_rdy), 32'd1);

    // Simultaneous read and write: write wins
    access(1'b1, 1'b1, 32'hE000_0000, 32'h0000_0055, rd, lat);
    chk("rw_ge_we", 32'(c_ge), 32'd1);
    chk("rw_periph", s_periph, 32'h0000_0055);
    chk("rw_rdy_cnt", 32'(c_rdy), 32'd1);

    // Keyboard: push 9 keys into depth-8 FIFO
    for (int k = 1; k <= 9; k++) begin
      ps2kb_key = 10'(k); ps2kb_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    ps2kb_valid = 1'b0;
    access(1'b0, 1'b1, 32'hD000_0004, 32'h0, rd, lat);
    chk("kb_status1", rd, 32'hC008_0001);
    access(1'b0, 1'b1, 32'hD000_0004, 32'h0, rd, lat);
    chk("kb_status2", rd, 32'h8008_0001);
    for (int k = 1; k <= 8; k++) begin
      access(1'b0, 1'b1, 32'hD000_0000, 32'h0, rd, lat);
      chk($sformatf("kb_pop%0d", k), rd, 32'h8000_0000 | (32'(9 - k) << 16) | 32'(k));
    end
    access(1'b0, 1'b1, 32'hD000_0000, 32'h0, rd, lat);
    chk("kb_pop_empty", rd, 32'h0);

    // VRAM write with delayed ack
    cpu_if.mem_w = 1'b1; cpu_if.addr_bus = 32'hC000_0040; cpu_if.Cpu_data2bus = 32'h0000_0ABC;
    vcnt = 0; c_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (vram_we) vcnt++;
      if (cpu_if.bus_ready) c_rdy++;
    end
    chk("vram_we_cycles", 32'(vcnt), 32'd5);
    chk("vram_no_rdy", 32'(c_rdy), 32'd0);
    chk("vram_addr", 32'(vram_addr), 32'h10);
    chk("vram_data", 32'(vram_data), 32'hABC);
    vram_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    vram_ack = 1'b0;
    chk("vram_rdy_after_ack", 32'(cpu_if.bus_ready), 32'd1);
    chk("vram_we_dropped", 32'(vram_we), 32'd0);
    cpu_if.mem_w = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("vram_rdy_single", 32'(cpu_if.bus_ready), 32'd0);

    // Reset while waiting in VWAIT, with one key buffered
    ps2kb_key = 10'h33; ps2kb_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    ps2kb_valid = 1'b0;
    cpu_if.mem_w = 1'b1; cpu_if.addr_bus = 32'hC000_0080; cpu_if.Cpu_data2bus = 32'h123;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("vwait_we_before_rst", 32'(vram_we), 32'd1);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_vwait_we", 32'(vram_we), 32'd0);
    chk("rst_vwait_rdy", 32'(cpu_if.bus_ready), 32'd0);
    cpu_if.mem_w = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b1, 32'hD000_0004, 32'h0, rd, lat);
    chk("rst_kb_empty", rd, 32'h0);
    chk("rst_idle_lat", 32'(lat), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
